// File: rtl/dpll_pkg.sv
// dpll_pkg
// Shared constants and types for the ring-oscillator trim control loop.
//   DPLL_CNT_W     : width of the period counter / captured count
//   DPLL_TRIM_BITS : number of thermometer trim lines
//   DPLL_TRIM_INIT : trim value loaded at reset
//   DPLL_TOL       : accepted error window (+/- oscillator cycles)
//   DPLL_LOCK_CNT  : consecutive in-window results required for lock
//   cmp_t          : classification of one captured period against div
package dpll_pkg;

    localparam int DPLL_CNT_W     = 8;
    localparam int DPLL_TRIM_BITS = 26;
    localparam int DPLL_TRIM_INIT = 13;
    localparam int DPLL_TOL       = 1;
    localparam int DPLL_LOCK_CNT  = 4;

    typedef enum logic [1:0] {
        CMP_SLOW = 2'd0,   // too few cycles per ref period: speed up (tval-1)
        CMP_OK   = 2'd1,   // inside the +/-TOL window
        CMP_FAST = 2'd2    // too many cycles per ref period: slow down (tval+1)
    } cmp_t;

endpackage

// File: rtl/dpll_ref_sync.sv
// dpll_ref_sync
// Brings the slow asynchronous reference into the oscillator domain and
// produces a single-cycle pulse per reference rising edge.
//   clock    : oscillator clock (rising edge)
//   reset    : asynchronous active-high reset, clears the chain to 0
//   ref_clk  : asynchronous reference input
//   ref_edge : one-cycle pulse, 2-3 clocks after a ref_clk rising edge
module dpll_ref_sync (
    input  logic clock,
    input  logic reset,
    input  logic ref_clk,
    output logic ref_edge
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = ref_clk;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    // s1 is the metastability-catching stage; the edge is taken one stage later.
    assign ref_edge = s2_q & ~s3_q;

endmodule

// File: rtl/dpll_trim_ctrl.sv
// dpll_trim_ctrl
// Counts oscillator cycles per reference period and nudges a thermometer trim
// code by one step per period until the count sits within +/-TOL of div.
//   clock      : oscillator clock, all state on its rising edge
//   reset      : asynchronous active-high reset
//   ref_clk    : slow external reference, asynchronous to clock
//   enable     : loop enable (level)
//   div        : target oscillator cycles per reference period
//   trim       : thermometer code, trim[i]=1 when i<tval (more ones = slower)
//   count_last : last captured period count
//   locked     : LOCK_CNT consecutive in-window results seen
module dpll_trim_ctrl
    import dpll_pkg::*;
#(
    parameter int CNT_W     = DPLL_CNT_W,
    parameter int TRIM_BITS = DPLL_TRIM_BITS,
    parameter int TRIM_INIT = DPLL_TRIM_INIT,
    parameter int TOL       = DPLL_TOL,
    parameter int LOCK_CNT  = DPLL_LOCK_CNT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ref_clk,
    input  logic                 enable,
    input  logic [CNT_W-1:0]     div,
    output logic [TRIM_BITS-1:0] trim,
    output logic [CNT_W-1:0]     count_last,
    output logic                 locked
);

    localparam int TV_W = $clog2(TRIM_BITS + 1);
    localparam int LC_W = $clog2(LOCK_CNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W:0]   TOL_W   = (CNT_W + 1)'(TOL);
    localparam logic [TV_W-1:0]  TV_MAX  = TV_W'(TRIM_BITS);
    localparam logic [TV_W-1:0]  TV_INIT = TV_W'(TRIM_INIT);
    localparam logic [LC_W-1:0]  LC_MAX  = LC_W'(LOCK_CNT);

    logic                ref_edge;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    count_last_q, count_last_d;
    logic                valid_q, valid_d;
    logic                pend_q, pend_d;
    logic [TV_W-1:0]     tval_q, tval_d;
    logic [LC_W-1:0]     lockcnt_q, lockcnt_d;
    logic                locked_q, locked_d;
    logic [CNT_W:0]      cl_ext, div_ext;
    cmp_t                cmp;

    dpll_ref_sync u_ref_sync (
        .clock    (clock),
        .reset    (reset),
        .ref_clk  (ref_clk),
        .ref_edge (ref_edge)
    );

    // One extra bit so div+TOL and count_last+TOL never wrap. A saturated
    // counter means the true period is unknown but long: classify as fast.
    always_comb begin
        cl_ext  = {1'b0, count_last_q};
        div_ext = {1'b0, div};
        cmp     = CMP_OK;
        if ((count_last_q == CNT_MAX) || (cl_ext > div_ext + TOL_W)) begin
            cmp = CMP_FAST;
        end else if (cl_ext + TOL_W < div_ext) begin
            cmp = CMP_SLOW;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        count_last_d = count_last_q;
        valid_d      = valid_q;
        pend_d       = 1'b0;
        tval_d       = tval_q;
        lockcnt_d    = lockcnt_q;
        locked_d     = locked_q;

        if (!enable) begin
            // Disabled wins over a coincident edge or pending compare; the trim
            // and last count are kept so the loop resumes from where it was.
            cnt_d     = '0;
            valid_d   = 1'b0;
            lockcnt_d = '0;
            locked_d  = 1'b0;
        end else begin
            if (ref_edge) begin
                count_last_d = cnt_q;
                cnt_d        = CNT_W'(1);
                valid_d      = 1'b1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            // The first edge after reset/enable only arms valid: the count it
            // captures does not span a full reference period.
            pend_d = ref_edge & valid_q;

            if (pend_q) begin
                unique case (cmp)
                    CMP_FAST: begin
                        if (tval_q != TV_MAX) tval_d = tval_q + TV_W'(1);
                        lockcnt_d = '0;
                    end
                    CMP_SLOW: begin
                        if (tval_q != '0) tval_d = tval_q - TV_W'(1);
                        lockcnt_d = '0;
                    end
                    default: begin
                        if (lockcnt_q != LC_MAX) lockcnt_d = lockcnt_q + LC_W'(1);
                    end
                endcase
                locked_d = (lockcnt_d == LC_MAX);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q        <= '0;
            count_last_q <= '0;
            valid_q      <= 1'b0;
            pend_q       <= 1'b0;
            tval_q       <= TV_INIT;
            lockcnt_q    <= '0;
            locked_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            count_last_q <= count_last_d;
            valid_q      <= valid_d;
            pend_q       <= pend_d;
            tval_q       <= tval_d;
            lockcnt_q    <= lockcnt_d;
            locked_q     <= locked_d;
        end
    end

    for (genvar gi = 0; gi < TRIM_BITS; gi++) begin : g_trim
        assign trim[gi] = (tval_q > TV_W'(gi));
    end

    assign count_last = count_last_q;
    assign locked     = locked_q;

endmodule
